// File: rtl/pipe_stage_skid.sv
// Pipeline stage with valid/ready handshake, optional 2-entry skid buffer and flush.
// Control bits are cleared on flush and masked on bubbles; data bits change only on load or reset.
module pipe_stage_skid #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 160,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    logic              h_valid;
    logic [CTRL_W-1:0] h_ctrl;
    logic [DATA_W-1:0] h_data;
    logic              accept;
    logic              pop;

    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = h_valid & out_ready & ~flush;
    assign out_valid = h_valid;
    assign out_ctrl  = h_valid ? h_ctrl : '0;
    assign out_data  = h_data;

    generate
        if (SKID != 0) begin : g_skid
            state_t            state;
            logic              skid_full;
            logic [CTRL_W-1:0] s_ctrl;
            logic [DATA_W-1:0] s_data;

            // in_ready comes straight from skid_full so upstream never sees out_ready combinationally.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state     <= EMPTY;
                    skid_full <= 1'b0;
                    h_ctrl    <= '0;
                    h_data    <= '0;
                    s_ctrl    <= '0;
                    s_data    <= '0;
                end else if (flush) begin
                    state     <= EMPTY;
                    skid_full <= 1'b0;
                    h_ctrl    <= '0;
                    s_ctrl    <= '0;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (accept) begin
                                h_ctrl <= in_ctrl;
                                h_data <= in_data;
                                state  <= ONE;
                            end
                        end
                        ONE: begin
                            if (accept && pop) begin
                                h_ctrl <= in_ctrl;
                                h_data <= in_data;
                            end else if (accept) begin
                                s_ctrl    <= in_ctrl;
                                s_data    <= in_data;
                                state     <= FULL;
                                skid_full <= 1'b1;
                            end else if (pop) begin
                                state <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (pop) begin
                                h_ctrl    <= s_ctrl;
                                h_data    <= s_data;
                                state     <= ONE;
                                skid_full <= 1'b0;
                            end
                        end
                        default: begin
                            state     <= EMPTY;
                            skid_full <= 1'b0;
                        end
                    endcase
                end
            end

            assign h_valid   = (state != EMPTY);
            assign in_ready  = ~skid_full;
            assign occupancy = state;
        end else begin : g_single
            logic valid_q;

            // Single register: a simultaneous pop frees the slot, so in_ready looks at out_ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    h_ctrl  <= '0;
                    h_data  <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                    h_ctrl  <= '0;
                end else if (accept) begin
                    valid_q <= 1'b1;
                    h_ctrl  <= in_ctrl;
                    h_data  <= in_data;
                end else if (pop) begin
                    valid_q <= 1'b0;
                end
            end

            assign h_valid   = valid_q;
            assign in_ready  = ~valid_q | out_ready;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

endmodule
